// File: rtl/serial_comparator.sv
// Bit-serial MSB-first magnitude comparator with registered Eq/gt/lt results and a done pulse.
// Optional macro EARLY_EXIT_EN: finish as soon as the first differing bit pair is accepted.
module serial_comparator #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a,
  input  logic b,
  output logic Eq,
  output logic gt,
  output logic lt,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dec_q, dec_d;
  logic          gti_q, gti_d;
  logic          lti_q, lti_d;
  logic          eq_q, eq_d;
  logic          gt_q, gt_d;
  logic          lt_q, lt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          diff_new;
  logic          last_bit;

  // First mismatch seen on the current bit pair decides the ordering
  assign diff_new = !dec_q && (a != b);

`ifdef EARLY_EXIT_EN
  assign last_bit = (cnt_q == LAST_CNT) || diff_new;
`else
  assign last_bit = (cnt_q == LAST_CNT);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    gti_d   = gti_q;
    lti_d   = lti_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start) begin
      // Start wins in every state; the bit pair in this cycle is dropped
      state_d = S_CMP;
      cnt_d   = '0;
      dec_d   = 1'b0;
      gti_d   = 1'b0;
      lti_d   = 1'b0;
      eq_d    = 1'b0;
      gt_d    = 1'b0;
      lt_d    = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        S_CMP: begin
          if (bit_valid) begin
            cnt_d = cnt_q + CW'(1);
            if (diff_new) begin
              dec_d = 1'b1;
              gti_d = a & ~b;
              lti_d = ~a & b;
            end
            if (last_bit) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              eq_d    = ~dec_d;
              gt_d    = gti_d;
              lt_d    = lti_d;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      gti_q   <= 1'b0;
      lti_q   <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      gti_q   <= gti_d;
      lti_q   <= lti_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
